// File: rtl/dco_core.sv
// rtl/dco_core.sv - digitally controlled oscillator with code resync/qualify and feedback divider
module dco_core #(
    parameter int BASE_HALF = 16,
    parameter int CODE_W    = 5,
    parameter int DIV_N     = 8
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] dco_code,
    input  logic              enable,
    output logic              dco_out,
    output logic              fb_clk,
    output logic [CODE_W-1:0] code_applied,
    output logic              code_update
);
    localparam int HW  = $clog2(BASE_HALF + 2**CODE_W) + 1;
    localparam int FBN = DIV_N / 2;
    localparam int FBW = (FBN > 1) ? $clog2(FBN) : 1;
    localparam logic [CODE_W-1:0] RST_CODE = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [HW-1:0]     HALF_MAX = HW'(BASE_HALF + 2**CODE_W - 1);
    localparam logic [FBW-1:0]    FB_LAST  = FBW'(FBN - 1);

    logic [CODE_W-1:0] sync1_q, sync2_q, pending_q, code_q;
    logic [CODE_W-1:0] pending_d, code_d;
    logic              stable_q, stable_d;
    logic [HW-1:0]     cnt_q, cnt_d;
    logic              dco_q, dco_d;
    logic              fb_q, fb_d;
    logic [FBW-1:0]    fb_cnt_q, fb_cnt_d;
    logic              update_q, update_d;

    logic [HW-1:0]     half_last;
    logic              running;
    logic              boundary;
    logic              qualified;

    always_comb begin
        half_last = HALF_MAX - {{(HW-CODE_W){1'b0}}, code_q} - HW'(1);
        // A high phase always runs to completion so the output never glitches
        running   = enable | dco_q;
        boundary  = running && (cnt_q == half_last);
        // s2 equal on three consecutive samples: the current one, the incoming one and the previous one
        qualified = stable_q && (sync1_q == sync2_q);

        stable_d  = (sync1_q == sync2_q);
        pending_d = qualified ? sync2_q : pending_q;
        update_d  = boundary && (pending_q != code_q);

        cnt_d    = cnt_q;
        dco_d    = dco_q;
        code_d   = code_q;
        fb_cnt_d = fb_cnt_q;
        fb_d     = fb_q;

        if (!running) begin
            cnt_d = '0;
        end else if (boundary) begin
            cnt_d  = '0;
            dco_d  = ~dco_q;
            code_d = pending_q;
            if (!dco_q) begin
                if (fb_cnt_q == FB_LAST) begin
                    fb_cnt_d = '0;
                    fb_d     = ~fb_q;
                end else begin
                    fb_cnt_d = fb_cnt_q + FBW'(1);
                end
            end
        end else begin
            cnt_d = cnt_q + HW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= RST_CODE;
            sync2_q   <= RST_CODE;
            stable_q  <= 1'b0;
            pending_q <= RST_CODE;
            code_q    <= RST_CODE;
            cnt_q     <= '0;
            dco_q     <= 1'b0;
            fb_cnt_q  <= '0;
            fb_q      <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            sync1_q   <= dco_code;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            dco_q     <= dco_d;
            fb_cnt_q  <= fb_cnt_d;
            fb_q      <= fb_d;
            update_q  <= update_d;
        end
    end

    assign dco_out      = dco_q;
    assign fb_clk       = fb_q;
    assign code_applied = code_q;
    assign code_update  = update_q;

endmodule

// File: tb/tb_dco_core.sv
// tb/tb_dco_core.sv - self-checking bench for dco_core against an event-scheduled model
module tb_dco_core;
    localparam int BASE_HALF = 16;
    localparam int CODE_W    = 5;
    localparam int DIV_N     = 8;

    logic              sys_clk  = 1'b0;
    logic              reset    = 1'b1;
    logic              enable   = 1'b0;
    logic [CODE_W-1:0] dco_code = 5'd16;
    logic              dco_out, fb_clk, code_update;
    logic [CODE_W-1:0] code_applied;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int cyc, m_next, m_first, m_rises, m_applied, m_pending, m_cur;
    bit m_idle, m_level, m_upd;

    dco_core #(.BASE_HALF(BASE_HALF), .CODE_W(CODE_W), .DIV_N(DIV_N)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .dco_code     (dco_code),
        .enable       (enable),
        .dco_out      (dco_out),
        .fb_clk       (fb_clk),
        .code_applied (code_applied),
        .code_update  (code_update)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int half_of(input int code);
        return BASE_HALF + (2**CODE_W - 1) - code;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: schedules the absolute cycle of each boundary; pending is the value first seen three samples ago
    always @(posedge sys_clk or negedge reset) begin : model
        int nx, ap, pd, cu, fs, rs, n;
        bit id, lv, up;
        if (!reset) begin
            cyc <= 0; m_next <= 0; m_first <= -100; m_rises <= 0;
            m_applied <= 16; m_pending <= 16; m_cur <= 16;
            m_idle <= 1'b1; m_level <= 1'b0; m_upd <= 1'b0;
        end else begin
            n = cyc + 1;
            nx = m_next; ap = m_applied; pd = m_pending; cu = m_cur; fs = m_first;
            rs = m_rises; id = m_idle; lv = m_level; up = 1'b0;
            if (!(enable || lv)) begin
                id = 1'b1;
            end else begin
                if (id) begin
                    id = 1'b0;
                    nx = n + half_of(ap) - 1;
                end
                if (n == nx) begin
                    up = (pd != ap);
                    ap = pd;
                    lv = !lv;
                    if (lv) rs++;
                    nx = n + half_of(ap);
                end
            end
            if (n == fs + 3) pd = cu;
            if (int'(dco_code) != cu) begin
                cu = int'(dco_code);
                fs = n;
            end
            cyc <= n; m_next <= nx; m_first <= fs; m_rises <= rs;
            m_applied <= ap; m_pending <= pd; m_cur <= cu;
            m_idle <= id; m_level <= lv; m_upd <= up;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("dco_out", dco_out, m_level);
            check("fb_clk", fb_clk, (m_rises / (DIV_N / 2)) % 2);
            check("code_applied", code_applied, m_applied);
            check("code_update", code_update, m_upd);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return dco_out;
            1:       return fb_clk;
            default: return code_update;
        endcase
    endfunction

    task automatic wait_edge(input string name, input int sel, input logic want,
                             input int budget, output int at);
        logic prev;
        int   i;
        bit   ok;
        prev = sig(sel); ok = 1'b0; at = -1; i = 0;
        while (!ok && i < budget) begin
            tick(1);
            i++;
            if (sig(sel) != prev) begin
                prev = sig(sel);
                if (prev == want) begin
                    ok = 1'b1;
                    at = cyc;
                end
            end
        end
        if (!ok) check({name, " timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, r1, r2, f1, f2, u, cnt, t0, t1, t2, i;
        logic prev;

        #2 reset = 1'b0;
        #1;
        check("rst_dco_out", dco_out, 0);
        check("rst_fb_clk", fb_clk, 0);
        check("rst_code_applied", code_applied, 16);
        check("rst_code_update", code_update, 0);
        chk_en = 1'b1;
        tick(3);
        reset = 1'b1;

        tick(20);
        check("idle_dco_out", dco_out, 0);
        check("idle_code_applied", code_applied, 16);

        enable = 1'b1;
        t = cyc;
        wait_edge("first_rise", 0, 1'b1, 200, r1);
        check("first_rise_delay", r1 - t, 31);
        wait_edge("rise_c16", 0, 1'b1, 200, r2);
        check("period_code16", r2 - r1, 62);
        wait_edge("fb_rise_a", 1, 1'b1, 1200, f1);
        wait_edge("fb_rise_b", 1, 1'b1, 1200, f2);
        check("fb_period_code16", f2 - f1, 496);

        dco_code = 5'd31;
        t = cyc;
        wait_edge("upd_16_31", 2, 1'b1, 100, u);
        check("upd_latency_window", int'((u - t >= 5) && (u - t <= 36)), 1);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            cnt += int'(code_update);
        end
        check("single_update_pulse", cnt, 0);
        check("applied_31", code_applied, 31);
        wait_edge("rise_c31_a", 0, 1'b1, 100, r1);
        wait_edge("rise_c31_b", 0, 1'b1, 100, r2);
        check("period_code31", r2 - r1, 32);

        dco_code = 5'd0;
        wait_edge("upd_31_0", 2, 1'b1, 100, u);
        wait_edge("rise_c0_a", 0, 1'b1, 200, r1);
        wait_edge("rise_c0_b", 0, 1'b1, 200, r2);
        check("period_code0", r2 - r1, 94);

        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            dco_code = (k % 2 == 0) ? 5'd1 : 5'd0;
            tick(1);
            cnt += int'(code_update);
        end
        check("toggle_no_update", cnt, 0);
        check("toggle_applied_0", code_applied, 0);
        dco_code = 5'd17;
        tick(60);
        check("applied_17", code_applied, 17);

        wait_edge("rise_c17", 0, 1'b1, 200, r1);
        tick(5);
        enable = 1'b0;
        wait_edge("fall_after_drop", 0, 1'b0, 100, f1);
        check("high_phase_len", f1 - r1, 30);
        cnt = 0;
        prev = dco_out;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (dco_out != prev) cnt++;
            prev = dco_out;
        end
        check("idle_no_toggle", cnt, 0);
        enable = 1'b1;
        t = cyc;
        wait_edge("restart_rise", 0, 1'b1, 100, r1);
        check("restart_delay", r1 - t, 30);

        dco_code = 5'd16;
        wait_edge("upd_17_16", 2, 1'b1, 100, u);
        i = 0;
        while ((m_next - cyc != 4) && i < 200) begin
            tick(1);
            i++;
        end
        check("collision_align", int'(m_next - cyc == 4), 1);
        dco_code = 5'd31;
        t = cyc;
        wait_edge("coll_t0", 0, !dco_out, 100, t0);
        check("collision_boundary_at", t0 - t, 4);
        wait_edge("coll_t1", 0, !dco_out, 100, t1);
        check("collision_old_half", t1 - t0, 31);
        wait_edge("coll_t2", 0, !dco_out, 100, t2);
        check("collision_new_half", t2 - t1, 16);

        i = 0;
        while (!(dco_out && fb_clk) && i < 600) begin
            tick(1);
            i++;
        end
        check("both_high_before_reset", int'(dco_out && fb_clk), 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_dco_out", dco_out, 0);
        check("midrst_fb_clk", fb_clk, 0);
        check("midrst_code_applied", code_applied, 16);
        check("midrst_code_update", code_update, 0);
        enable = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(20);
        check("post_rst_idle_dco", dco_out, 0);
        check("post_rst_idle_code", code_applied, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dco_core.md
# dco_core

Digitally controlled oscillator for the ADPLL, directly downstream of the PLL controller. It consumes the 5-bit `dco_code` from the controller and produces the oscillator output `dco_out`, whose half-period is set by the code. It also produces the divided feedback clock `fb_clk` that returns to the phase/frequency detector. `dco_code` arrives from the `phase_clk` domain and is resynchronised and qualified before it is applied, so the output never glitches.

## Interface
- `BASE_HALF`, default 16: minimum half-period, in `sys_clk` cycles (≥2).
- `CODE_W`, default 5: width of `dco_code`.
- `DIV_N`, default 8: feedback divide ratio; must be even and ≥2.
- `sys_clk`  input  1: high-speed oscillator time base; the only clock.
- `reset`  input  1: asynchronous, active-low reset.
- `dco_code`  input  CODE_W: frequency code from the controller; asynchronous to `sys_clk`.
- `enable`  input  1: oscillator run enable; synchronous to `sys_clk`.
- `dco_out`  output  1: oscillator output, registered.
- `fb_clk`  output  1: `dco_out` divided by DIV_N, 50% duty, registered.
- `code_applied`  output  CODE_W: code currently setting the half-period.
- `code_update`  output  1: one-cycle pulse when `code_applied` changes value.

## Operation
- **Synchroniser.** Each `dco_code` bit passes through a 2-flop synchroniser (`s2`).
- **Qualifier.**
  - `pending` loads `s2` only when `s2` has held the same value for 3 consecutive `sys_clk` samples.
  - Otherwise `pending` holds its value.
- **Half-period.**
  - half = BASE_HALF + (2^CODE_W − 1 − `code_applied`), computed at CODE_W+2 bits or wider.
  - A higher code gives a higher frequency.
  - With defaults: code 31 → 16, code 16 → 31, code 0 → 47.
- **Counter.**
  - `cnt` counts 0 … half−1.
  - At terminal count (a "boundary"): `cnt` returns to 0, `dco_out` toggles, and `code_applied` loads `pending`.
  - The new half is used from the next half-period onward.
  - The code never changes mid-half-period.
- **code_update.** Asserted on the cycle after a boundary load in which `pending` ≠ old `code_applied`.
- **Enable.**
  - With `enable`=0 and `dco_out`=0: `cnt` is held at 0 and `dco_out` stays 0.
  - With `enable`=0 and `dco_out`=1: the current high half-period completes, `dco_out` falls at its boundary, then the block idles.
  - When `enable` returns to 1: counting restarts from 0, and the first rising edge comes half cycles later.
- **Feedback divider.**
  - `fb_cnt` counts `dco_out` rising edges, 0 … DIV_N/2−1.
  - `fb_clk` toggles on the rising edge that wraps `fb_cnt`.
  - `fb_cnt` and `fb_clk` hold while idle.

## Timing
- **Reset values:**
  - `dco_out`=0, `fb_clk`=0, `code_update`=0.
  - `code_applied`=2^(CODE_W−1) (16).
  - `pending` = same value (16); synchroniser flops = 16.
  - `cnt`=0, `fb_cnt`=0, qualifier history cleared.
- Reset is asynchronous on assertion and mid-operation; all state returns to the reset values immediately. The first `sys_clk` edge after deassertion starts counting if `enable`=1.
- **Code latency:**
  - `dco_code` stable from edge k.
  - `s2` valid at k+2.
  - `pending` updated at k+4.
  - Applied at the first boundary ≥ k+5.
- A code that does not stay stable long enough is never applied; for example, a bit that toggles every cycle is never applied.
- **Output period:** `dco_out` period = 2·half `sys_clk` cycles, exact, with no jitter for a constant code.
- **Feedback period:** `fb_clk` period = DIV_N · `dco_out` period.
- **Simultaneous events:**
  - A `pending` update on a boundary cycle: the boundary loads the old `pending`, and the new value waits for the next boundary.
  - `enable` falling on a boundary where `dco_out` would go 1→0: the fall happens and the block idles.

## Test plan
1. **Reset and idle.** Assert `reset`=0 mid-run → all outputs at reset values asynchronously. Hold `enable`=0 after release → `dco_out` stays 0 and `code_applied`=16.
2. **Nominal period.** `enable`=1, code 16 → `dco_out` period 62 cycles, `fb_clk` period 496 cycles.
3. **Code step.** Code 16→31 → `code_update` pulses once after the first boundary ≥5 cycles later; half becomes 16, giving a period of 32. Code 31→0 → period 94.
4. **Unstable code.** Toggle `dco_code` bit 0 every cycle for 100 cycles → `code_applied` unchanged and no `code_update`. Then hold 17 → applied.
5. **Enable drop while high.** Drop `enable` mid high phase → the high phase lasts the full half; then `dco_out` stays 0 and `fb_clk` is frozen. Re-enable → the first rise comes half cycles later.
6. **Boundary collision.** Make `pending` change on a boundary cycle → the old code is used for that half-period and the new code for the next.
